// File: rtl/render_pkg.sv
// Shared types and helpers for the per-pixel layer fetch scheduler.
package render_pkg;

    localparam int NUM_LAYERS = 3;
    localparam int RGB_BITS   = 24;

    typedef enum logic [2:0] {
        IDLE,
        RD_MAP,
        RD_PLAYER,
        RD_BULLET,
        DONE
    } fetch_state_e;

    typedef enum logic [1:0] {
        LAYER_MAP    = 2'd0,
        LAYER_PLAYER = 2'd1,
        LAYER_BULLET = 2'd2
    } layer_e;

    typedef struct packed {
        logic [RGB_BITS/3-1:0] blue;
        logic [RGB_BITS/3-1:0] green;
        logic [RGB_BITS/3-1:0] red;
    } rgb_t;

    // First requested layer at or after index start, in map->player->bullet order.
    function automatic fetch_state_e pick_layer(input logic [NUM_LAYERS-1:0] req, input int start);
        if (start <= 0 && req[LAYER_MAP])    return RD_MAP;
        if (start <= 1 && req[LAYER_PLAYER]) return RD_PLAYER;
        if (start <= 2 && req[LAYER_BULLET]) return RD_BULLET;
        return DONE;
    endfunction

endpackage

// File: rtl/layer_fetch_sched.sv
// Shares one single-port colour memory between map, player and bullet layers,
// presenting the fetched colours one pixel slot later.
module layer_fetch_sched
    import render_pkg::*;
#(
    parameter int COLOR_BITS = 24,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pix_ce_i,
    input  logic                  display_enable_i,
    input  logic                  map_enable_i,
    input  logic                  map_req_i,
    input  logic [ADDR_W-1:0]     map_addr_i,
    input  logic                  player_req_i,
    input  logic [ADDR_W-1:0]     player_addr_i,
    input  logic                  bullet_req_i,
    input  logic [ADDR_W-1:0]     bullet_addr_i,
    output logic                  mem_rd_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [COLOR_BITS-1:0] mem_data_i,
    output logic [COLOR_BITS-1:0] map_rgb_o,
    output logic [COLOR_BITS-1:0] player_rgb_o,
    output logic [COLOR_BITS-1:0] bullet_rgb_o,
    output logic                  display_enable_o,
    output logic                  map_enable_o,
    output logic                  overrun_o
);

    fetch_state_e          state_q;
    logic [NUM_LAYERS-1:0] req_q;
    logic [ADDR_W-1:0]     addr_q [NUM_LAYERS];
    logic                  den_q;
    logic                  men_q;
    logic [COLOR_BITS-1:0] cap_q  [NUM_LAYERS];
    logic [COLOR_BITS-1:0] out_q  [NUM_LAYERS];
    logic                  den_out_q;
    logic                  men_out_q;
    logic                  overrun_q;
    logic                  ret_q;
    layer_e                ret_layer_q;

    logic                  reading;
    layer_e                cur_layer;
    logic                  fire;

    always_comb begin
        reading    = 1'b0;
        cur_layer  = LAYER_MAP;
        mem_addr_o = '0;
        case (state_q)
            RD_MAP: begin
                reading    = 1'b1;
                cur_layer  = LAYER_MAP;
                mem_addr_o = addr_q[0];
            end
            RD_PLAYER: begin
                reading    = 1'b1;
                cur_layer  = LAYER_PLAYER;
                mem_addr_o = addr_q[1];
            end
            RD_BULLET: begin
                reading    = 1'b1;
                cur_layer  = LAYER_BULLET;
                mem_addr_o = addr_q[2];
            end
            default: ;
        endcase
        // The slot-boundary cycle belongs to nobody, so no read may fire in it.
        mem_rd_o = reading & ~pix_ce_i;
        fire     = mem_rd_o & mem_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            den_q       <= 1'b0;
            men_q       <= 1'b0;
            den_out_q   <= 1'b0;
            men_out_q   <= 1'b0;
            overrun_q   <= 1'b0;
            ret_q       <= 1'b0;
            ret_layer_q <= LAYER_MAP;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                addr_q[l] <= '0;
                cap_q[l]  <= '0;
                out_q[l]  <= '0;
            end
        end else begin
            ret_q       <= fire;
            ret_layer_q <= cur_layer;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (ret_q && ret_layer_q == layer_e'(l)) begin
                    cap_q[l] <= mem_data_i;
                end
            end

            if (pix_ce_i) begin
                // Data returning in the boundary cycle still belongs to the finishing slot.
                for (int l = 0; l < NUM_LAYERS; l++) begin
                    out_q[l] <= (ret_q && ret_layer_q == layer_e'(l)) ? mem_data_i : cap_q[l];
                    cap_q[l] <= '0;
                end
                den_out_q <= den_q;
                men_out_q <= men_q;
                den_q     <= display_enable_i;
                men_q     <= map_enable_i;
                req_q     <= {bullet_req_i, player_req_i, map_req_i};
                addr_q[0] <= map_addr_i;
                addr_q[1] <= player_addr_i;
                addr_q[2] <= bullet_addr_i;
                if (reading) begin
                    overrun_q <= 1'b1;
                end
                state_q <= pick_layer({bullet_req_i, player_req_i, map_req_i}, 0);
            end else if (fire) begin
                state_q <= pick_layer(req_q, int'(cur_layer) + 1);
            end
        end
    end

    assign map_rgb_o        = out_q[0];
    assign player_rgb_o     = out_q[1];
    assign bullet_rgb_o     = out_q[2];
    assign display_enable_o = den_out_q;
    assign map_enable_o     = men_out_q;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_layer_fetch_sched.sv
// Directed self-checking bench for layer_fetch_sched with a one-cycle-latency memory model.
module tb_layer_fetch_sched;

    localparam int COLOR_BITS = 24;
    localparam int ADDR_W     = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  pix_ce_i = 1'b0;
    logic                  display_enable_i = 1'b0;
    logic                  map_enable_i = 1'b0;
    logic                  map_req_i = 1'b0;
    logic [ADDR_W-1:0]     map_addr_i = '0;
    logic                  player_req_i = 1'b0;
    logic [ADDR_W-1:0]     player_addr_i = '0;
    logic                  bullet_req_i = 1'b0;
    logic [ADDR_W-1:0]     bullet_addr_i = '0;
    logic                  mem_rd_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic                  mem_ready_i = 1'b1;
    logic [COLOR_BITS-1:0] mem_data_i = '0;
    logic [COLOR_BITS-1:0] map_rgb_o;
    logic [COLOR_BITS-1:0] player_rgb_o;
    logic [COLOR_BITS-1:0] bullet_rgb_o;
    logic                  display_enable_o;
    logic                  map_enable_o;
    logic                  overrun_o;

    int checks = 0;
    int failures = 0;
    int rdHighCnt = 0;
    int boundaryViol = 0;
    int rdBase;

    layer_fetch_sched #(.COLOR_BITS(COLOR_BITS), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pix_ce_i(pix_ce_i),
        .display_enable_i(display_enable_i), .map_enable_i(map_enable_i),
        .map_req_i(map_req_i), .map_addr_i(map_addr_i),
        .player_req_i(player_req_i), .player_addr_i(player_addr_i),
        .bullet_req_i(bullet_req_i), .bullet_addr_i(bullet_addr_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
        .map_rgb_o(map_rgb_o), .player_rgb_o(player_rgb_o), .bullet_rgb_o(bullet_rgb_o),
        .display_enable_o(display_enable_o), .map_enable_o(map_enable_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory returns addr*0x010101 one cycle after a fired read, junk otherwise.
    always @(posedge clk_i) begin
        if (mem_rd_o && mem_ready_i) mem_data_i <= 24'(mem_addr_o) * 24'h010101;
        else                         mem_data_i <= 24'hDEAD00;
    end

    always @(posedge clk_i) begin
        if (mem_rd_o) rdHighCnt <= rdHighCnt + 1;
        if (mem_rd_o && pix_ce_i) boundaryViol <= boundaryViol + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one pix_ce_i cycle with the given slot inputs; returns 1ns after the following negedge.
    task automatic applyStimulus(input logic [2:0] reqs, input logic [15:0] am, input logic [15:0] ap,
                                 input logic [15:0] ab, input logic den, input logic men);
        {bullet_req_i, player_req_i, map_req_i} = reqs;
        map_addr_i       = am;
        player_addr_i    = ap;
        bullet_addr_i    = ab;
        display_enable_i = den;
        map_enable_i     = men;
        pix_ce_i         = 1'b1;
        @(negedge clk_i);
        pix_ce_i = 1'b0;
        #1;
    endtask

    task automatic checkColours(input string tag, input logic [23:0] m, input logic [23:0] p, input logic [23:0] b);
        checkOutput({tag, "_map"},    32'(map_rgb_o),    32'(m));
        checkOutput({tag, "_player"}, 32'(player_rgb_o), 32'(p));
        checkOutput({tag, "_bullet"}, 32'(bullet_rgb_o), 32'(b));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        checkColours("reset", 24'h0, 24'h0, 24'h0);
        checkOutput("reset_den", 32'(display_enable_o), 32'd0);
        checkOutput("reset_men", 32'(map_enable_o), 32'd0);
        checkOutput("reset_overrun", 32'(overrun_o), 32'd0);
        checkOutput("reset_rd", 32'(mem_rd_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Scenario 1: 4-cycle slots, all layers
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b1, 1'b1);
        repeat (3) @(negedge clk_i);
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b1, 1'b1);
        checkColours("s1", 24'h101010, 24'h202020, 24'h303030);
        checkOutput("s1_overrun", 32'(overrun_o), 32'd0);
        checkOutput("s1_den", 32'(display_enable_o), 32'd1);
        checkOutput("s1_men", 32'(map_enable_o), 32'd1);
        repeat (3) @(negedge clk_i);

        // Scenario 2: player only
        rdBase = rdHighCnt;
        applyStimulus(3'b010, 16'h10, 16'h20, 16'h30, 1'b0, 1'b0);
        checkColours("s1b", 24'h101010, 24'h202020, 24'h303030);
        checkOutput("s2_rd_c1", 32'(mem_rd_o), 32'd1);
        checkOutput("s2_addr_c1", 32'(mem_addr_o), 32'h20);
        @(negedge clk_i); #1;
        checkOutput("s2_rd_c2", 32'(mem_rd_o), 32'd0);
        repeat (2) @(negedge clk_i);
        checkOutput("s2_rd_count", 32'(rdHighCnt - rdBase), 32'd1);

        // Scenario 3: memory stall in RD_PLAYER, 6-cycle slot
        applyStimulus(3'b111, 16'h11, 16'h22, 16'h33, 1'b1, 1'b1);
        checkColours("s2", 24'h0, 24'h202020, 24'h0);
        checkOutput("s2_den", 32'(display_enable_o), 32'd0);
        @(negedge clk_i); mem_ready_i = 1'b0; #1;
        checkOutput("s3_addr_c2", 32'(mem_addr_o), 32'h22);
        checkOutput("s3_rd_c2", 32'(mem_rd_o), 32'd1);
        @(negedge clk_i); #1;
        checkOutput("s3_addr_c3", 32'(mem_addr_o), 32'h22);
        @(negedge clk_i); mem_ready_i = 1'b1; #1;
        checkOutput("s3_addr_c4", 32'(mem_addr_o), 32'h22);
        @(negedge clk_i); #1;
        checkOutput("s3_addr_c5", 32'(mem_addr_o), 32'h33);
        @(negedge clk_i);

        // Scenario 4: 3-cycle slot overruns on bullet
        applyStimulus(3'b111, 16'h44, 16'h55, 16'h66, 1'b0, 1'b1);
        checkColours("s3", 24'h111111, 24'h222222, 24'h333333);
        checkOutput("s3_overrun", 32'(overrun_o), 32'd0);
        repeat (2) @(negedge clk_i);
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b0, 1'b1);
        checkColours("s4", 24'h444444, 24'h555555, 24'h0);
        checkOutput("s4_overrun", 32'(overrun_o), 32'd1);
        repeat (3) @(negedge clk_i);

        // Scenario 5: enable alignment
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b1, 1'b0);
        checkOutput("s4_overrun_sticky", 32'(overrun_o), 32'd1);
        checkOutput("s5_map_prev", 32'(map_rgb_o), 32'h101010);
        checkOutput("s5_den_prev", 32'(display_enable_o), 32'd0);
        checkOutput("s5_men_prev", 32'(map_enable_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("s5_den_early", 32'(display_enable_o), 32'd0);
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b0, 1'b1);
        checkOutput("s5_den", 32'(display_enable_o), 32'd1);
        checkOutput("s5_men", 32'(map_enable_o), 32'd0);
        repeat (3) @(negedge clk_i);

        // Scenario 6: reset during RD_PLAYER
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b1, 1'b1);
        @(negedge clk_i); #1;
        checkOutput("s6_addr_pre", 32'(mem_addr_o), 32'h20);
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        checkColours("s6_rst", 24'h0, 24'h0, 24'h0);
        checkOutput("s6_rst_rd", 32'(mem_rd_o), 32'd0);
        checkOutput("s6_rst_overrun", 32'(overrun_o), 32'd0);
        checkOutput("s6_rst_den", 32'(display_enable_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b1, 1'b1);
        repeat (3) @(negedge clk_i);
        applyStimulus(3'b111, 16'h10, 16'h20, 16'h30, 1'b1, 1'b1);
        checkColours("s6", 24'h101010, 24'h202020, 24'h303030);
        checkOutput("s6_overrun", 32'(overrun_o), 32'd0);
        repeat (3) @(negedge clk_i);

        checkOutput("rd_in_boundary", 32'(boundaryViol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
